// File: rtl/regulator_trim_ctrl.sv
// SAR trim calibration controller: searches the regulator trim code MSB-first,
// waits SETTLE_CYCLES after each code change, then samples the comparator.
module regulator_trim_ctrl #(
  parameter int unsigned       TRIM_W        = 4,
  parameter int unsigned       SETTLE_CYCLES = 16,
  parameter logic [TRIM_W-1:0] TRIM_DEFAULT  = {1'b1, {(TRIM_W-1){1'b0}}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cmp_hi,
  input  logic              cfg_we,
  input  logic [TRIM_W-1:0] cfg_trim,
  output logic [TRIM_W-1:0] trim,
  output logic              busy,
  output logic              done,
  output logic              locked
);

  localparam int unsigned       CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned       IDX_W    = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_MSB  = IDX_W'(TRIM_W - 1);
  localparam logic [TRIM_W-1:0] TRIM_MSB = {1'b1, {(TRIM_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TRIM_W-1:0]   trim_q, trim_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                locked_q, locked_d;

  // Next-state and datapath update for the search FSM.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    trim_d   = trim_q;
    locked_d = locked_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          trim_d   = TRIM_MSB;
          idx_d    = IDX_MSB;
          cnt_d    = '0;
          locked_d = 1'b0;
          state_d  = ST_SETTLE;
        end else if (cfg_we) begin
          trim_d   = cfg_trim;
          locked_d = 1'b0;
        end else begin
          trim_d   = trim_q;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        // vout above target means the code under test is too high: drop the bit.
        if (cmp_hi) begin
          trim_d[idx_q] = 1'b0;
        end else begin
          trim_d[idx_q] = trim_q[idx_q];
        end
        if (idx_q != '0) begin
          trim_d[idx_q - IDX_W'(1)] = 1'b1;
          idx_d   = idx_q - IDX_W'(1);
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          locked_d = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
  assign done_d = (state_d == ST_DONE);

  // State and registered outputs; reset drops any partial search.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= IDX_MSB;
      cnt_q    <= '0;
      trim_q   <= TRIM_DEFAULT;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      trim_q   <= trim_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      locked_q <= locked_d;
    end
  end

  assign trim   = trim_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_regulator_trim_ctrl.sv
// Scoreboard bench: expected calibration results are queued at start and
// compared by a monitor whenever a DUT raises done.
module tb_regulator_trim_ctrl;

  typedef struct packed {
    logic [3:0]  trim;
    logic [31:0] lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, cmp_hi, cfg_we;
  logic [3:0] cfg_trim, trim;
  logic       busy, done, locked;
  logic       start1, cmp1, cfg_we1;
  logic [3:0] cfg_trim1, trim1;
  logic       busy1, done1, locked1;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   t0     = 0;
  int   t1     = 0;
  int   mode   = 0;
  exp_t q0[$];
  exp_t q1[$];

  regulator_trim_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cmp_hi(cmp_hi),
    .cfg_we(cfg_we), .cfg_trim(cfg_trim), .trim(trim), .busy(busy),
    .done(done), .locked(locked)
  );

  regulator_trim_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .cmp_hi(cmp1),
    .cfg_we(cfg_we1), .cfg_trim(cfg_trim1), .trim(trim1), .busy(busy1),
    .done(done1), .locked(locked1)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Comparator plant: vout above target when trim > 10. dut1 sees noise except
  // in the cycle before each sampling edge (even edges after start).
  initial forever begin
    @(negedge clk);
    case (mode)
      1:       cmp_hi = 1'b1;
      2:       cmp_hi = 1'b0;
      default: cmp_hi = (trim > 4'd10);
    endcase
    if (((cyc + 1 - t1) % 2) == 0) cmp1 = (trim1 > 4'd10);
    else                           cmp1 = 1'($urandom_range(0, 1));
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 trim=%b expected no done", trim);
        end else begin
          e = q0.pop_front();
          chk("done_trim", 32'(trim), 32'(e.trim));
          chk("done_latency", 32'(cyc - t0), e.lat);
          chk("done_locked", 32'(locked), 32'd1);
          chk("done_busy", 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done1 === 1'b1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done1: got done=1 trim=%b expected no done", trim1);
        end else begin
          e = q1.pop_front();
          chk("done1_trim", 32'(trim1), 32'(e.trim));
          chk("done1_latency", 32'(cyc - t1), e.lat);
          chk("done1_locked", 32'(locked1), 32'd1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
  endtask

  task automatic drain0(input int budget);
    repeat (budget) begin
      @(negedge clk);
      #1;
      if (q0.size() == 0) break;
    end
    chk("drain0", 32'(q0.size()), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; cfg_we = 1'b0; cfg_trim = 4'b0000; cmp_hi = 1'b0;
    start1 = 1'b0; cfg_we1 = 1'b0; cfg_trim1 = 4'b0000; cmp1 = 1'b0;
    tick(3);
    chk("rst_trim", 32'(trim), 32'b1000);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(2);

    // Nominal convergence on threshold 10.
    mode = 0;
    q0.push_back('{trim: 4'b1010, lat: 32'd68});
    pulse_start();
    chk("seq0", 32'(trim), 32'b1000);
    chk("busy_after_start", 32'(busy), 32'd1);
    tick(17);
    chk("seq1", 32'(trim), 32'b1100);
    tick(17);
    chk("seq2", 32'(trim), 32'b1010);
    tick(17);
    chk("seq3", 32'(trim), 32'b1011);
    tick(16);
    chk("busy_e67", 32'(busy), 32'd1);
    chk("done_e67", 32'(done), 32'd0);
    tick(2);
    chk("done_e69", 32'(done), 32'd0);
    chk("locked_e69", 32'(locked), 32'd1);
    chk("final_trim", 32'(trim), 32'b1010);
    drain0(5);

    // Boundaries.
    mode = 1;
    q0.push_back('{trim: 4'b0000, lat: 32'd68});
    pulse_start();
    drain0(80);
    mode = 2;
    q0.push_back('{trim: 4'b1111, lat: 32'd68});
    pulse_start();
    drain0(80);

    // Requests while busy and in the DONE cycle are dropped.
    mode = 0;
    q0.push_back('{trim: 4'b1010, lat: 32'd68});
    pulse_start();
    tick(10);
    @(negedge clk);
    start = 1'b1; cfg_we = 1'b1; cfg_trim = 4'b0011;
    @(posedge clk);
    #1;
    start = 1'b0; cfg_we = 1'b0;
    chk("busy_ignore_trim", 32'(trim), 32'b1000);
    tick(57);
    chk("done_cycle", 32'(done), 32'd1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_start_busy", 32'(busy), 32'd0);
    tick(3);
    chk("done_start_busy2", 32'(busy), 32'd0);
    chk("done_start_locked", 32'(locked), 32'd1);
    chk("done_start_trim", 32'(trim), 32'b1010);
    drain0(2);

    // Manual write, then start and cfg_we together.
    @(negedge clk);
    cfg_we = 1'b1; cfg_trim = 4'b0101;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    chk("cfg_trim", 32'(trim), 32'b0101);
    chk("cfg_locked", 32'(locked), 32'd0);
    tick(2);
    q0.push_back('{trim: 4'b1010, lat: 32'd68});
    @(negedge clk);
    start = 1'b1; cfg_we = 1'b1; cfg_trim = 4'b0011;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0; cfg_we = 1'b0;
    chk("both_trim", 32'(trim), 32'b1000);
    chk("both_busy", 32'(busy), 32'd1);
    drain0(80);

    // Asynchronous reset mid-calibration.
    pulse_start();
    tick(20);
    chk("mid_trim", 32'(trim), 32'b1100);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_trim", 32'(trim), 32'b1000);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_locked", 32'(locked), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    tick(3);
    @(negedge clk);
    reset_n = 1'b1;
    tick(80);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_trim", 32'(trim), 32'b1000);

    // Short settle with comparator noise outside sampling.
    q1.push_back('{trim: 4'b1010, lat: 32'd8});
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    t1 = cyc;
    start1 = 1'b0;
    chk("s1_busy", 32'(busy1), 32'd1);
    repeat (20) begin
      @(negedge clk);
      #1;
      if (q1.size() == 0) break;
    end
    chk("drain1", 32'(q1.size()), 32'd0);
    tick(2);
    chk("s1_idle", 32'(busy1), 32'd0);

    chk("final_q0", 32'(q0.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regulator_trim_ctrl.md
# regulator_trim_ctrl

Digital calibration controller for the mixed-signal regulator's 4-bit `trim` input. It runs a successive-approximation (SAR) search on `trim`, waits a programmable settling time after each code change, and samples an external comparator that reports whether `vout` is above target. It then locks and holds the resulting code. It sits in the digital domain next to the regulator and is the only driver of its `trim` port.

## Interface

Parameters:
- `TRIM_W`, 4: trim code width; must match the regulator's `trim` width.
- `SETTLE_CYCLES`, 16: clock cycles waited after each trim change before sampling; legal range 1..255.
- `TRIM_DEFAULT`, 4'b1000: `trim` value driven out of reset (mid-scale).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  controller clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  level-sampled request to begin a calibration.
- `cmp_hi`  in  1  comparator output; 1 = `vout` above target. Already synchronised to `clk` upstream.
- `cfg_we`  in  1  manual trim write strobe.
- `cfg_trim`  in  TRIM_W  manual trim value.
- `trim`  out  TRIM_W  drives the regulator trim input.
- `busy`  out  1  calibration in progress.
- `done`  out  1  one-cycle pulse when calibration completes.
- `locked`  out  1  `trim` holds a calibrated result.

## Operation

Reset values (asynchronous, while `reset_n` = 0):
- `trim` = `TRIM_DEFAULT`
- `busy` = 0, `done` = 0, `locked` = 0
- state = IDLE, bit index = `TRIM_W-1`, settle counter = 0

States:
- **IDLE**: `busy` = 0.
  - `start` = 1 → load `trim` = only MSB set (`1000`), bit index = `TRIM_W-1`, counter = 0, go to SETTLE, clear `locked`.
  - `cfg_we` = 1 (without `start`) → `trim` = `cfg_trim`, clear `locked`.
  - If `start` and `cfg_we` are asserted in the same cycle, `start` wins and `cfg_we` is dropped.
- **SETTLE**: `busy` = 1. The counter increments each cycle; when it equals `SETTLE_CYCLES-1`, go to SAMPLE. `trim` is stable throughout.
- **SAMPLE**: `busy` = 1, one cycle, `cmp_hi` sampled.
  - `cmp_hi` = 1 → clear `trim[bit index]`.
  - If bit index > 0: set `trim[bit index - 1]`, decrement bit index, counter = 0, go to SETTLE.
  - If bit index = 0: go to DONE with the final `trim`.
- **DONE**: one cycle. `done` = 1, `locked` = 1, `busy` = 0. Next state is IDLE. `start` is ignored in this cycle.

Rules:
- `start` and `cfg_we` are ignored while `busy` = 1; no queuing.
- `locked` stays 1 until the next accepted `start`, an accepted `cfg_we`, or reset.
- `cmp_hi` is sampled only in SAMPLE and ignored otherwise.
- Search direction: a higher trim code gives a higher `vout`.
- Boundary results:
  - `cmp_hi` always 1 → final `trim` = 0.
  - `cmp_hi` always 0 → final `trim` = all ones.
  - No wrap-around and no arithmetic overflow is possible.
- Settle counter width: `$clog2(SETTLE_CYCLES+1)`.
- Reset mid-calibration: outputs return to their reset values immediately (asynchronously). No partial result is kept.

## Timing

- `start` accepted at edge E0 (IDLE): `trim` = `1000` and `busy` = 1 become visible after E0.
- Each bit takes `SETTLE_CYCLES + 1` cycles (settle + sample). The new trim code is visible the cycle after SAMPLE.
- `done` is high for exactly one cycle, starting `TRIM_W*(SETTLE_CYCLES+1)` cycles after E0 (68 cycles at defaults).
- `locked` rises together with `done`.
- `busy` falls on the same edge that raises `done`.
- Earliest next accepted `start`: the cycle after `done`.
- `cfg_we` accepted at edge E updates `trim` after E (one-cycle latency).

## Test plan

1. **Reset values**: apply reset → `trim` = `1000`, `busy` = `done` = `locked` = 0. Assert reset for 3 cycles mid-calibration → same values immediately, and the FSM restarts only on a new `start`.
2. **SAR convergence**: bench model `cmp_hi` = (`trim` > 10), defaults, pulse `start` → `trim` sequence is `1000`, `1100`, `1010`, `1011`, then final `1010`; `done` pulses 68 cycles after start; `locked` = 1.
3. **Boundaries**: `cmp_hi` tied to 1 → final `trim` = `0000`. `cmp_hi` tied to 0 → final `trim` = `1111`. Both complete in 68 cycles.
4. **Settling**: `SETTLE_CYCLES` = 1 → `done` 8 cycles after start. Toggle `cmp_hi` randomly during SETTLE with the correct value only in SAMPLE → result is unaffected.
5. **Ignored requests**: `start` and `cfg_we` (`cfg_trim` = `0011`) asserted while busy → no restart, no trim change, result identical to scenario 2. `start` asserted in the DONE cycle → ignored.
6. **Manual write**: after a lock, `cfg_we` with `cfg_trim` = `0101` in IDLE → `trim` = `0101` next cycle and `locked` = 0. `start` and `cfg_we` in the same cycle → calibration starts and `trim` = `1000`.
